// File: rtl/hndshk_dest_rx.sv
// Destination-side receiver for a four-phase req/ack CDC handshake.
// Synchronizes src_req into dest_clk, captures src_data, pulses dest_strobe,
// returns dest_ack to the source and flags a sticky ack-high timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ack low; waiting for synchronized req with dest_ready high
// ACK_HIGH | word captured, ack high; waiting for synchronized req low
module hndshk_dest_rx #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic                  dest_clk,
  input  logic                  dest_reset_n,
  input  logic                  src_req,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  dest_ready,
  output logic                  dest_ack,
  output logic                  dest_strobe,
  output logic [DATA_WIDTH-1:0] dest_data,
  output logic [31:0]           xfer_count,
  output logic                  proto_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACK_HIGH = 2'b01
  } state_t;

  // With the timeout disabled the counter simply saturates at its maximum.
  localparam bit          TIMEOUT_EN = (ACK_TIMEOUT != 0);
  localparam logic [15:0] CNT_LIMIT  = TIMEOUT_EN ? 16'(ACK_TIMEOUT) : 16'hFFFF;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  state_t                 state_q,  state_d;
  logic                   ack_q,    ack_d;
  logic                   strobe_q, strobe_d;
  logic [DATA_WIDTH-1:0]  data_q,   data_d;
  logic [31:0]            xfer_q,   xfer_d;
  logic [15:0]            cnt_q,    cnt_d;
  logic                   err_q,    err_d;

  // src_req synchronizer; the only place the asynchronous request is sampled
  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_req};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // State and registered outputs, all cleared asynchronously
  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      strobe_q <= 1'b0;
      data_q   <= '0;
      xfer_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      xfer_q   <= xfer_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Next-state and next-output logic for the handshake FSM
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    strobe_d = 1'b0;
    data_d   = data_q;
    xfer_d   = xfer_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        cnt_d = '0;
        if (req_s && dest_ready) begin
          data_d   = src_data;
          strobe_d = 1'b1;
          ack_d    = 1'b1;
          xfer_d   = xfer_q + 32'd1;
          state_d  = ACK_HIGH;
        end
      end
      ACK_HIGH: begin
        ack_d = 1'b1;
        if (!req_s) begin
          ack_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          if (cnt_q != CNT_LIMIT) begin
            cnt_d = cnt_q + 16'd1;
          end
          if (TIMEOUT_EN && (cnt_d == CNT_LIMIT)) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        ack_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign dest_ack    = ack_q;
  assign dest_strobe = strobe_q;
  assign dest_data   = data_q;
  assign xfer_count  = xfer_q;
  assign proto_err   = err_q;

endmodule

// File: tb/tb_hndshk_dest_rx.sv
// Bench for hndshk_dest_rx: two instances (2- and 3-stage synchronizers,
// ack timeout of 8) driven by a handshaking source model and compared
// against a transaction-level scoreboard.
module tb_hndshk_dest_rx;

  localparam int TIMEOUT = 8;
  localparam int LIMIT   = 40;

  logic        dest_clk;
  logic        rst_n      [2];
  logic        src_req    [2];
  logic [31:0] src_data   [2];
  logic        dest_ready [2];
  logic        ack        [2];
  logic        strobe     [2];
  logic [31:0] ddata      [2];
  logic [31:0] xcnt       [2];
  logic        err        [2];

  int          n_chk = 0;
  int          n_err = 0;

  int unsigned m_cnt  [2];
  logic [31:0] m_data [2];
  bit          m_err  [2];

  hndshk_dest_rx #(.DATA_WIDTH(32), .SYNC_STAGES(2), .ACK_TIMEOUT(TIMEOUT)) u_dut_s2 (
    .dest_clk(dest_clk), .dest_reset_n(rst_n[0]), .src_req(src_req[0]),
    .src_data(src_data[0]), .dest_ready(dest_ready[0]), .dest_ack(ack[0]),
    .dest_strobe(strobe[0]), .dest_data(ddata[0]), .xfer_count(xcnt[0]),
    .proto_err(err[0]));

  hndshk_dest_rx #(.DATA_WIDTH(32), .SYNC_STAGES(3), .ACK_TIMEOUT(TIMEOUT)) u_dut_s3 (
    .dest_clk(dest_clk), .dest_reset_n(rst_n[1]), .src_req(src_req[1]),
    .src_data(src_data[1]), .dest_ready(dest_ready[1]), .dest_ack(ack[1]),
    .dest_strobe(strobe[1]), .dest_data(ddata[1]), .xfer_count(xcnt[1]),
    .proto_err(err[1]));

  initial dest_clk = 1'b0;
  always #5 dest_clk = ~dest_clk;

  function automatic int sync_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic wait_strobe(input int k, output int n);
    n = 0;
    do begin
      @(negedge dest_clk);
      n++;
    end while (!strobe[k] && n < LIMIT);
  endtask

  task automatic wait_ack_low(input int k, output int n);
    n = 0;
    do begin
      @(negedge dest_clk);
      n++;
    end while (ack[k] && n < LIMIT);
  endtask

  task automatic check_idle_outputs(input int k);
    check_val("rst_ack",    ack[k],    0);
    check_val("rst_strobe", strobe[k], 0);
    check_val("rst_data",   ddata[k],  0);
    check_val("rst_count",  xcnt[k],   0);
    check_val("rst_err",    err[k],    0);
  endtask

  // One full four-phase handshake. bp = cycles of extra backpressure,
  // hold = cycles the source keeps req high after seeing the strobe cycle.
  task automatic do_xfer(input int k, input logic [31:0] d, input int bp, input int hold);
    int n;
    int edges_hi;
    src_data[k]   = d;
    dest_ready[k] = (bp == 0);
    src_req[k]    = 1'b1;
    if (bp > 0) begin
      repeat (sync_of(k) + 1 + bp) begin
        @(negedge dest_clk);
        check_val("bp_strobe", strobe[k], 0);
        check_val("bp_ack",    ack[k],    0);
      end
      dest_ready[k] = 1'b1;
      wait_strobe(k, n);
      check_val("bp_latency", n, 1);
    end else begin
      wait_strobe(k, n);
      check_val("req_latency", n, sync_of(k) + 1);
    end
    m_cnt[k]++;
    m_data[k] = d;
    check_val("cap_data",  ddata[k], m_data[k]);
    check_val("cap_count", xcnt[k],  m_cnt[k]);
    check_val("cap_ack",   ack[k],   1);
    check_val("cap_err",   err[k],   m_err[k]);
    dest_ready[k] = 1'($urandom_range(0, 1));
    @(negedge dest_clk);
    edges_hi = 1;
    check_val("strobe_width", strobe[k], 0);
    check_val("data_held",    ddata[k],  m_data[k]);
    for (int i = 0; i < hold; i++) begin
      @(negedge dest_clk);
      edges_hi++;
      check_val("hold_ack", ack[k], 1);
      check_val("hold_err", err[k], m_err[k] || (edges_hi >= TIMEOUT));
    end
    src_req[k]  = 1'b0;
    src_data[k] = $urandom;
    // Ack-high cycles with req still high keep accruing while the fall syncs in.
    if (1 + hold + sync_of(k) >= TIMEOUT) m_err[k] = 1'b1;
    wait_ack_low(k, n);
    check_val("ack_fall_latency", n, sync_of(k) + 1);
    check_val("post_data",  ddata[k],  m_data[k]);
    check_val("post_err",   err[k],    m_err[k]);
    check_val("post_count", xcnt[k],   m_cnt[k]);
    check_val("post_strobe", strobe[k], 0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; src_req[k] = 1'b0; src_data[k] = '0; dest_ready[k] = 1'b1;
      m_cnt[k] = 0; m_data[k] = '0; m_err[k] = 1'b0;
    end
    repeat (3) @(negedge dest_clk);
    for (int k = 0; k < 2; k++) check_idle_outputs(k);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (2) @(negedge dest_clk);

    for (int i = 1; i <= 7; i++) do_xfer(0, 32'(i), 0, 0);
    check_val("b2b_count", xcnt[0], 7);
    check_val("b2b_err",   err[0],  0);

    do_xfer(0, 32'hDEADBEEF, 0, 0);
    do_xfer(0, 32'hCAFEF00D, 10, 1);

    for (int i = 0; i < 15; i++) begin
      do_xfer(0, $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
              int'($urandom_range(0, 3)));
    end
    check_val("rand_err", err[0], 0);

    do_xfer(0, 32'h0BAD_0001, 0, 10);
    check_val("timeout_sticky", err[0], 1);
    do_xfer(0, 32'h600D_0002, 0, 0);
    check_val("after_timeout_count", xcnt[0], m_cnt[0]);

    src_data[0] = 32'h1234_5678;
    src_req[0]  = 1'b1;
    wait_strobe(0, n);
    check_val("pre_rst_latency", n, 3);
    @(negedge dest_clk);
    check_val("pre_rst_ack", ack[0], 1);
    #2;
    rst_n[0]   = 1'b0;
    src_req[0] = 1'b0;
    #1;
    check_idle_outputs(0);
    m_cnt[0] = 0; m_data[0] = '0; m_err[0] = 1'b0;
    repeat (2) @(negedge dest_clk);
    rst_n[0] = 1'b1;
    repeat (2) @(negedge dest_clk);
    check_val("post_rst_ack", ack[0], 0);
    do_xfer(0, 32'hA5A5_5A5A, 0, 0);
    check_val("post_rst_count", xcnt[0], 1);

    do_xfer(1, 32'hDEADBEEF, 0, 0);
    for (int i = 0; i < 6; i++) begin
      do_xfer(1, $urandom, ($urandom_range(0, 2) == 0) ? 2 : 0, int'($urandom_range(0, 3)));
    end
    do_xfer(1, 32'h0000_FFFF, 0, 9);
    check_val("s3_timeout", err[1], 1);
    check_val("s3_count", xcnt[1], m_cnt[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
